// File: rtl/brisc_pkg.sv
// Shared core types: memory request/response payloads and the memory arbiter's state encoding.
package brisc_pkg;

  localparam int unsigned ADDR_LEN    = 32;
  localparam int unsigned LINE_LEN    = 128;
  localparam int unsigned NUM_MEM_REQ = 2;

  typedef struct packed {
    logic                valid;
    logic                rw;
    logic [ADDR_LEN-1:0] addr;
    logic [LINE_LEN-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                ready;
    logic [ADDR_LEN-1:0] addr;
    logic [LINE_LEN-1:0] data;
  } mem_resp_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first valid index at or after start, wrapping.
module rr_picker #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(start) + k) % N;
      if (!any && valid[IW'(cand)]) begin
        any                 = 1'b1;
        idx                 = IW'(cand);
        onehot[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between the caches; one transaction in flight at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority, otherwise fixed priority (index 0 wins).
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_MEM_REQ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  mem_req_t                   req [NUM_REQ],
  output logic [NUM_REQ-1:0]         arbiter_grant,
  output mem_resp_t                  resp,
  output mem_req_t                   mem_req,
  input  mem_resp_t                  mem_resp,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  mem_req_t             lat_req;
  mem_req_t             win_req;
  logic                 lat_en;
  logic [NUM_REQ-1:0]   valid_vec;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [IW-1:0]        start_ptr;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = req[i].valid;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Search resumes just after whoever finished last.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state_q == BUSY && mem_resp.ready) begin
      rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid  (valid_vec),
    .start  (start_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    win_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) win_req = mem_req_t'(win_req | req[i]);
    end
  end

  // Next state; the grant strobe follows mem_resp.ready combinationally while BUSY.
  always_comb begin
    state_d       = state_q;
    lat_en        = 1'b0;
    arbiter_grant = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          lat_en  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp.ready) begin
          arbiter_grant[owner] = 1'b1;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) arbiter_grant = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner   <= '0;
      busy    <= 1'b0;
      lat_req <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == BUSY);
      if (lat_en) begin
        owner   <= pick_idx;
        lat_req <= win_req;
      end
    end
  end

  // Latched request is presented for the whole BUSY period, independent of the live inputs.
  always_comb begin
    mem_req = '0;
    if (state_q == BUSY) begin
      mem_req       = lat_req;
      mem_req.valid = 1'b1;
    end
  end

  assign resp = mem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int NR = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR    = 1'b1;
  localparam int FIRST = 1;
`else
  localparam bit RR    = 1'b0;
  localparam int FIRST = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  mem_req_t       req [NR];
  mem_resp_t      mem_resp;
  logic [NR-1:0]  arbiter_grant;
  mem_resp_t      resp;
  mem_req_t       mem_req;
  logic [0:0]     owner;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int gcount = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: at most one outstanding request, owned by m_owner.
  bit       m_busy  = 1'b0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_start = 0;
  int       m_i     = 0;
  mem_req_t m_lat   = '0;

  mem_req_t      e_req;
  logic [NR-1:0] e_grant;
  logic [LINE_LEN-1:0] meml;

  mem_arbiter #(.NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .arbiter_grant (arbiter_grant),
    .resp          (resp),
    .mem_req       (mem_req),
    .mem_resp      (mem_resp),
    .owner         (owner),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_t mk(input bit v, input bit rw, input logic [ADDR_LEN-1:0] a,
                                  input logic [LINE_LEN-1:0] d);
    mem_req_t r;
    r.valid = v; r.rw = rw; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic mem_resp_t mkr(input bit rdy, input logic [ADDR_LEN-1:0] a,
                                    input logic [LINE_LEN-1:0] d);
    mem_resp_t r;
    r.ready = rdy; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic logic [LINE_LEN-1:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_lat = '0;
    end else if (m_busy) begin
      if (mem_resp.ready) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
    end else begin
      m_start = RR ? m_ptr : 0;
      for (int k = 0; k < NR; k++) begin
        m_i = (m_start + k) % NR;
        if (!m_busy && req[m_i].valid) begin
          m_busy = 1'b1; m_owner = m_i; m_lat = req[m_i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_req = '0;
      if (m_busy) begin
        e_req = m_lat;
        e_req.valid = 1'b1;
      end
      e_grant = (m_busy && mem_resp.ready && !reset) ? (NR'(1) << m_owner) : '0;
      chk("model_grant", 256'(arbiter_grant), 256'(e_grant));
      chk("model_mem_req", 256'(mem_req), 256'(e_req));
      chk("model_busy", 256'(busy), 256'(m_busy));
      chk("model_owner", 256'(owner), 256'(m_owner));
      chk("model_resp", 256'(resp), 256'(mem_resp));
      if (arbiter_grant != '0) gcount++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int g0;

  initial begin
    req[0] = '0; req[1] = '0; mem_resp = '0;
    meml = {4{32'hDEADBEEF}};
    reset = 1'b1;
    step(); step();
    chk_en = 1'b1;
    at_neg();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_owner", 256'(owner), 256'(0));
    chk("rst_mem_req", 256'(mem_req), 256'(0));
    chk("rst_grant", 256'(arbiter_grant), 256'(0));
    step();
    reset = 1'b0;

    // Single dcache read, memory ready on the third BUSY cycle.
    g0 = gcount;
    req[0] = mk(1'b1, 1'b0, 32'h100, '0);
    at_neg();
    chk("t1_idle_valid", 256'(mem_req.valid), 256'(0));
    step();
    for (int c = 0; c < 3; c++) begin
      mem_resp = mkr(c == 2, 32'h100, meml);
      if (c == 2) req[0] = '0;
      at_neg();
      chk("t1_valid", 256'(mem_req.valid), 256'(1));
      chk("t1_rw", 256'(mem_req.rw), 256'(0));
      chk("t1_addr", 256'(mem_req.addr), 256'(32'h100));
      if (c == 2) begin
        chk("t1_grant", 256'(arbiter_grant), 256'(2'b01));
        chk("t1_data", 256'(resp.data), 256'(meml));
      end
      step();
    end
    mem_resp = '0;
    at_neg();
    chk("t1_idle_after", 256'(busy), 256'(0));
    chk("t1_one_grant", 256'(gcount - g0), 256'(1));
    step();

    // Both caches request at once.
    req[0] = mk(1'b1, 1'b0, 32'h200, rline());
    req[1] = mk(1'b1, 1'b0, 32'h300, rline());
    step();
    mem_resp = mkr(1'b1, 32'h0, meml);
    at_neg();
    chk("t2_first_owner", 256'(owner), 256'(FIRST));
    chk("t2_first_grant", 256'(arbiter_grant), 256'(NR'(1) << FIRST));
    step();
    req[FIRST] = '0;
    mem_resp = '0;
    at_neg();
    chk("t2_gap_valid", 256'(mem_req.valid), 256'(0));
    step();
    mem_resp = mkr(1'b1, 32'h0, meml);
    at_neg();
    chk("t2_second_owner", 256'(owner), 256'(1 - FIRST));
    chk("t2_second_addr", 256'(mem_req.addr), 256'(FIRST == 0 ? 32'h300 : 32'h200));
    chk("t2_second_grant", 256'(arbiter_grant), 256'(NR'(1) << (1 - FIRST)));
    step();
    req[0] = '0; req[1] = '0; mem_resp = '0;
    step();

    // Owner withdraws after issue; latched request must persist.
    req[0] = mk(1'b1, 1'b1, 32'h400, meml);
    step();
    req[0] = mk(1'b0, 1'b0, 32'h999, '0);
    for (int c = 0; c < 3; c++) begin
      mem_resp = mkr(c == 2, 32'h0, '0);
      at_neg();
      chk("t3_addr", 256'(mem_req.addr), 256'(32'h400));
      chk("t3_data", 256'(mem_req.data), 256'(meml));
      if (c == 2) chk("t3_grant", 256'(arbiter_grant), 256'(2'b01));
      step();
    end
    mem_resp = '0;
    req[1] = mk(1'b1, 1'b0, 32'h500, '0);
    step();
    mem_resp = mkr(1'b1, 32'h0, '0);
    at_neg();
    chk("t3_next_addr", 256'(mem_req.addr), 256'(32'h500));
    chk("t3_next_grant", 256'(arbiter_grant), 256'(2'b10));
    step();
    req[1] = '0; mem_resp = '0;
    step();

    // Write-back then fill read presented in the grant cycle.
    req[0] = mk(1'b1, 1'b1, 32'hAA00, meml);
    step();
    mem_resp = mkr(1'b1, 32'hAA00, '0);
    req[0] = mk(1'b1, 1'b0, 32'hBB00, '0);
    at_neg();
    chk("t4_wb_rw", 256'(mem_req.rw), 256'(1));
    chk("t4_wb_grant", 256'(arbiter_grant), 256'(2'b01));
    step();
    mem_resp = '0;
    at_neg();
    chk("t4_gap_valid", 256'(mem_req.valid), 256'(0));
    step();
    req[0] = '0;
    at_neg();
    chk("t4_fill_rw", 256'(mem_req.rw), 256'(0));
    chk("t4_fill_addr", 256'(mem_req.addr), 256'(32'hBB00));
    step();
    mem_resp = mkr(1'b1, 32'hBB00, meml);
    step();
    mem_resp = '0;
    step();

    // Spurious ready while IDLE.
    mem_resp = mkr(1'b1, 32'h0, meml);
    for (int c = 0; c < 2; c++) begin
      at_neg();
      chk("t5_grant", 256'(arbiter_grant), 256'(0));
      chk("t5_busy", 256'(busy), 256'(0));
      step();
    end
    mem_resp = '0;

    // Reset while BUSY.
    req[1] = mk(1'b1, 1'b0, 32'h600, '0);
    step();
    req[1] = '0;
    reset = 1'b1;
    at_neg();
    chk("t6_busy_before", 256'(busy), 256'(1));
    step();
    reset = 1'b0;
    mem_resp = mkr(1'b1, 32'h0, '0);
    at_neg();
    chk("t6_valid", 256'(mem_req.valid), 256'(0));
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_owner", 256'(owner), 256'(0));
    chk("t6_grant", 256'(arbiter_grant), 256'(0));
    step();
    mem_resp = '0;

    // Randomized traffic, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) begin
        req[i] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom), rline());
      end
      mem_resp = mkr($urandom_range(0, 2) == 0, 32'($urandom), rline());
      step();
    end

    reset = 1'b0;
    req[0] = '0; req[1] = '0; mem_resp = '0;
    step(); step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
